// File: rtl/alu_op_issue_if.sv
// Valid/ready bundle between instruction fetch, the ALU op issue buffer and execute.
// The slave modport is the issue buffer; the master modport is the side driving it.
interface alu_op_issue_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       alu_op;
  logic [5:0]       funct;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [15:0]      out_imm;
  logic             out_illegal;
  logic             err_sticky;
  logic [CNT_W-1:0] issue_cnt;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, alu_op, funct, out_rs, out_rt, out_imm,
           out_illegal, err_sticky, issue_cnt
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, alu_op, funct, out_rs, out_rt, out_imm,
           out_illegal, err_sticky, issue_cnt
  );
endinterface

// File: rtl/alu_op_issue.sv
// Decodes KGPMini instructions into ALU op/funct and issues them to execute through
// a 2-entry FIFO; flags illegal opcodes and counts completed issues.
module alu_op_issue #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  alu_op_issue_if.slave bus
);

  typedef struct packed {
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        illegal;
  } entry_t;

  entry_t           mem_reg [2];
  entry_t           wr_entry;
  entry_t           head;
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic [1:0]       count_next;
  logic [CNT_W-1:0] issue_cnt_reg;
  logic             err_sticky_reg;
  logic             empty;
  logic             full;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count_reg == 2'd0);
  assign full  = (count_reg == 2'd2);

  // flush discards any write and read presented in the same cycle
  assign wr_en = bus.in_valid & ~full & ~flush;
  assign rd_en = ~empty & bus.out_ready & ~flush;

  always_comb begin
    wr_entry         = '0;
    wr_entry.rs      = bus.in_instr[25:21];
    wr_entry.rt      = bus.in_instr[20:16];
    wr_entry.imm     = bus.in_instr[15:0];
    case (bus.in_instr[31:26])
      6'b000000: begin
        wr_entry.alu_op = 3'b111;
        wr_entry.funct  = bus.in_instr[5:0];
      end
      6'b000001: wr_entry.alu_op = 3'b001;
      6'b000010: wr_entry.alu_op = 3'b010;
      6'b000011: wr_entry.alu_op = 3'b001;
      6'b000100: wr_entry.alu_op = 3'b001;
      6'b000101: wr_entry.alu_op = 3'b100;
      6'b000110: wr_entry.alu_op = 3'b011;
      default:   wr_entry.illegal = 1'b1;
    endcase
  end

  // Storage needs no reset: nothing is visible unless occupancy says so.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (wr_en && (wr_ptr_reg == 1'(gi)))
        mem_reg[gi] <= wr_entry;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({wr_en, rd_en})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      count_reg      <= 2'd0;
      issue_cnt_reg  <= '0;
      err_sticky_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      count_reg      <= 2'd0;
      err_sticky_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (wr_en)
        wr_ptr_reg <= ~wr_ptr_reg;
      if (rd_en) begin
        rd_ptr_reg    <= ~rd_ptr_reg;
        issue_cnt_reg <= issue_cnt_reg + 1'b1;
        if (head.illegal)
          err_sticky_reg <= 1'b1;
      end
    end
  end

  assign head = mem_reg[rd_ptr_reg];

  assign bus.in_ready    = ~full;
  assign bus.out_valid   = ~empty;
  assign bus.alu_op      = empty ? 3'd0  : head.alu_op;
  assign bus.funct       = empty ? 6'd0  : head.funct;
  assign bus.out_rs      = empty ? 5'd0  : head.rs;
  assign bus.out_rt      = empty ? 5'd0  : head.rt;
  assign bus.out_imm     = empty ? 16'd0 : head.imm;
  assign bus.out_illegal = empty ? 1'b0  : head.illegal;
  assign bus.err_sticky  = err_sticky_reg;
  assign bus.issue_cnt   = issue_cnt_reg;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed-vector bench for alu_op_issue (CNT_W=4 so counter wrap is reachable).
module tb_alu_op_issue;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  alu_op_issue_if #(.CNT_W(CNT_W)) bus ();

  alu_op_issue #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    vectors++;
    if (bus.issue_cnt !== 4'd0) begin
      miscompares++; $display("FAIL reset_issue_cnt got=%0d exp=0", bus.issue_cnt);
    end
    vectors++;
    if ({bus.alu_op, bus.funct, bus.out_imm, bus.out_illegal, bus.err_sticky} !== 27'd0) begin
      miscompares++; $display("FAIL reset_outputs got=%h exp=0",
                              {bus.alu_op, bus.funct, bus.out_imm, bus.out_illegal, bus.err_sticky});
    end
    tick();
    rst = 1'b0;
    $display("reset released");
  endtask

  // R-type issued straight through: cnt 0 -> 1
  task automatic test_rtype();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0022_1805;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.alu_op !== 3'b111 || bus.funct !== 6'b000101) begin
      miscompares++; $display("FAIL rtype_decode got v=%b op=%b f=%b exp v=1 op=111 f=000101",
                              bus.out_valid, bus.alu_op, bus.funct);
    end
    vectors++;
    if (bus.out_rs !== 5'd1 || bus.out_rt !== 5'd2 || bus.out_imm !== 16'h1805) begin
      miscompares++; $display("FAIL rtype_fields got rs=%0d rt=%0d imm=%h exp 1 2 1805",
                              bus.out_rs, bus.out_rt, bus.out_imm);
    end
    tick();
    vectors++;
    if (bus.issue_cnt !== 4'd1 || bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL rtype_issue got cnt=%0d v=%b exp cnt=1 v=0",
                              bus.issue_cnt, bus.out_valid);
    end
    $display("rtype 00221805 done cnt=%0d", bus.issue_cnt);
  endtask

  // addi: cnt 1 -> 2
  task automatic test_addi();
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0422_0010;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.alu_op !== 3'b001 || bus.funct !== 6'd0 || bus.out_illegal !== 1'b0) begin
      miscompares++; $display("FAIL addi_decode got op=%b f=%b ill=%b exp 001 000000 0",
                              bus.alu_op, bus.funct, bus.out_illegal);
    end
    vectors++;
    if (bus.out_rs !== 5'd1 || bus.out_rt !== 5'd2 || bus.out_imm !== 16'h0010) begin
      miscompares++; $display("FAIL addi_fields got rs=%0d rt=%0d imm=%h exp 1 2 0010",
                              bus.out_rs, bus.out_rt, bus.out_imm);
    end
    tick();
    $display("addi 04220010 done cnt=%0d", bus.issue_cnt);
  endtask

  // compi, lw, branch with execute stalled: branch must be refused; cnt 2 -> 4
  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0800_0000;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_ready_occ1 got=%b exp=1", bus.in_ready);
    end
    bus.in_instr = 32'h0C00_0000;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL b2b_ready_full got=%b exp=0", bus.in_ready);
    end
    bus.in_instr = 32'h1400_0000;
    tick();
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.alu_op !== 3'b010) begin
      miscompares++; $display("FAIL b2b_hold got rdy=%b v=%b op=%b exp 0 1 010",
                              bus.in_ready, bus.out_valid, bus.alu_op);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.alu_op !== 3'b001 || bus.issue_cnt !== 4'd3) begin
      miscompares++; $display("FAIL b2b_second got v=%b op=%b cnt=%0d exp 1 001 3",
                              bus.out_valid, bus.alu_op, bus.issue_cnt);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.issue_cnt !== 4'd4) begin
      miscompares++; $display("FAIL b2b_drained got v=%b cnt=%0d exp 0 4",
                              bus.out_valid, bus.issue_cnt);
    end
    $display("back_to_back done cnt=%0d", bus.issue_cnt);
  endtask

  // illegal opcode then flush with simultaneous write+read: cnt 4 -> 5, flush keeps 5
  task automatic test_illegal_flush();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'hFC00_003F;
    tick();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_illegal !== 1'b1 || bus.alu_op !== 3'd0 || bus.funct !== 6'd0 ||
        bus.err_sticky !== 1'b0) begin
      miscompares++; $display("FAIL illegal_decode got ill=%b op=%b f=%b err=%b exp 1 000 000000 0",
                              bus.out_illegal, bus.alu_op, bus.funct, bus.err_sticky);
    end
    bus.out_ready = 1'b1;
    tick();
    vectors++;
    if (bus.err_sticky !== 1'b1 || bus.issue_cnt !== 4'd5) begin
      miscompares++; $display("FAIL illegal_sticky got err=%b cnt=%0d exp 1 5",
                              bus.err_sticky, bus.issue_cnt);
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0400_0001;
    tick();
    tick();
    vectors++;
    if (bus.err_sticky !== 1'b1 || bus.out_valid !== 1'b1) begin
      miscompares++; $display("FAIL sticky_held got err=%b v=%b exp 1 1",
                              bus.err_sticky, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.err_sticky !== 1'b0 || bus.issue_cnt !== 4'd5 ||
        bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL flush got v=%b err=%b cnt=%0d rdy=%b exp 0 0 5 1",
                              bus.out_valid, bus.err_sticky, bus.issue_cnt, bus.in_ready);
    end
    $display("illegal/flush done cnt=%0d", bus.issue_cnt);
  endtask

  task automatic test_rst_mid();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h1800_0000;
    tick();
    tick();
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_full got rdy=%b exp 0", bus.in_ready);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.issue_cnt !== 4'd0) begin
      miscompares++; $display("FAIL rstmid got v=%b rdy=%b cnt=%0d exp 0 1 0",
                              bus.out_valid, bus.in_ready, bus.issue_cnt);
    end
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    $display("reset mid-stream done");
  endtask

  // Preload one entry, then 17 write+read cycles at occupancy 1; cnt wraps 15 -> 0 -> 1
  task automatic test_wrap();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0400_0064;
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus.in_instr = {16'h0400, 16'(i)};
      tick();
      vectors++;
      if (bus.issue_cnt !== 4'((i + 1) % 16) || bus.out_valid !== 1'b1 ||
          bus.out_imm !== 16'(i)) begin
        miscompares++; $display("FAIL wrap_%0d got cnt=%0d v=%b imm=%0d exp cnt=%0d v=1 imm=%0d",
                                i, bus.issue_cnt, bus.out_valid, bus.out_imm, (i + 1) % 16, i);
      end
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.issue_cnt !== 4'd1) begin
      miscompares++; $display("FAIL wrap_final got cnt=%0d exp 1", bus.issue_cnt);
    end
    tick();
    $display("wrap done cnt=%0d", bus.issue_cnt);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'd0;
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    test_rtype();
    test_addi();
    test_back_to_back();
    test_illegal_flush();
    test_rst_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
